// File: rtl/frogger_tick_pkg.sv
// Shared constants, types and helpers for the Frogger game tick scheduler.
package frogger_tick_pkg;

    localparam int unsigned DEF_CLK_HZ  = 50_000_000;
    localparam int unsigned DEF_BASE_HZ = 60;
    localparam int unsigned DEF_NUM_CH  = 4;
    localparam int unsigned DEF_PER_W   = 8;
    localparam int unsigned DEF_SEC_W   = 8;

    typedef logic [DEF_PER_W-1:0] period_t;
    typedef logic [DEF_SEC_W-1:0] sec_t;

    function automatic int unsigned prescale(input int unsigned clk_hz, input int unsigned base_hz);
        return clk_hz / base_hz;
    endfunction

    // Counter width for a modulus n, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/game_tick_scheduler_if.sv
// Control and strobe bundle between the game logic and the tick scheduler.
interface game_tick_scheduler_if
    import frogger_tick_pkg::*;
#(
    parameter int unsigned NUM_CH = DEF_NUM_CH,
    parameter int unsigned PER_W  = DEF_PER_W,
    parameter int unsigned SEC_W  = DEF_SEC_W
);
    localparam int unsigned CH_W = cnt_width(NUM_CH);

    logic              run;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [PER_W-1:0]  cfg_period;
    logic              sec_load;
    logic [SEC_W-1:0]  sec_value;
    logic              base_tick;
    logic [NUM_CH-1:0] ch_tick;
    logic              sec_tick;
    logic [SEC_W-1:0]  sec_count;
    logic              time_up;

    modport master (
        output run, cfg_we, cfg_ch, cfg_period, sec_load, sec_value,
        input  base_tick, ch_tick, sec_tick, sec_count, time_up
    );

    modport slave (
        input  run, cfg_we, cfg_ch, cfg_period, sec_load, sec_value,
        output base_tick, ch_tick, sec_tick, sec_count, time_up
    );

endinterface

// File: rtl/tick_channel.sv
// One lane channel: programmable divider of the base tick producing a one-cycle strobe.
module tick_channel #(
    parameter int unsigned PER_W = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             run,
    input  logic             base_tick,
    input  logic             we,
    input  logic [PER_W-1:0] period,
    output logic             tick
);

    logic [PER_W-1:0] period_q, period_d;
    logic [PER_W-1:0] count_q,  count_d;
    logic             tick_q,   tick_d;

    // A write restarts the lane and swallows any coincident base tick.
    always_comb begin
        period_d = period_q;
        count_d  = count_q;
        tick_d   = 1'b0;
        if (we) begin
            period_d = period;
            count_d  = '0;
        end else if (run && base_tick && (period_q != '0)) begin
            if (count_q == period_q - PER_W'(1)) begin
                count_d = '0;
                tick_d  = 1'b1;
            end else begin
                count_d = count_q + PER_W'(1);
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            period_q <= '0;
            count_q  <= '0;
            tick_q   <= 1'b0;
        end else begin
            period_q <= period_d;
            count_q  <= count_d;
            tick_q   <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/game_tick_scheduler.sv
// Frogger timing controller: base-tick prescaler, per-lane movement strobes and
// a seconds countdown, all delivered as single-cycle enables on Clk.
module game_tick_scheduler
    import frogger_tick_pkg::*;
#(
    parameter int unsigned CLK_HZ  = DEF_CLK_HZ,
    parameter int unsigned BASE_HZ = DEF_BASE_HZ,
    parameter int unsigned NUM_CH  = DEF_NUM_CH,
    parameter int unsigned PER_W   = DEF_PER_W,
    parameter int unsigned SEC_W   = DEF_SEC_W
) (
    input logic                  Clk,
    input logic                  Reset,
    game_tick_scheduler_if.slave bus
);

    localparam int unsigned PRESCALE = prescale(CLK_HZ, BASE_HZ);
    localparam int unsigned PS_W     = cnt_width(PRESCALE);
    localparam int unsigned SD_W     = cnt_width(BASE_HZ);
    localparam int unsigned CH_W     = cnt_width(NUM_CH);

    logic [PS_W-1:0]   presc_q,     presc_d;
    logic              base_tick_q, base_tick_d;
    logic [SD_W-1:0]   subdiv_q,    subdiv_d;
    logic              sec_tick_q,  sec_tick_d;
    logic [SEC_W-1:0]  sec_count_q, sec_count_d;
    logic              time_up_q,   time_up_d;
    logic [NUM_CH-1:0] ch_tick;

    // Prescaler: base tick is registered on the wrap from PRESCALE-1.
    always_comb begin
        presc_d     = presc_q;
        base_tick_d = 1'b0;
        if (bus.run) begin
            if (presc_q == PS_W'(PRESCALE - 1)) begin
                presc_d     = '0;
                base_tick_d = 1'b1;
            end else begin
                presc_d = presc_q + PS_W'(1);
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        tick_channel #(.PER_W(PER_W)) u_ch (
            .Clk       (Clk),
            .Reset     (Reset),
            .run       (bus.run),
            .base_tick (base_tick_q),
            .we        (bus.cfg_we && (bus.cfg_ch == CH_W'(i))),
            .period    (bus.cfg_period),
            .tick      (ch_tick[i])
        );
    end

    // Seconds sub-divider and countdown; a load restarts the second and beats a decrement.
    always_comb begin
        subdiv_d    = subdiv_q;
        sec_tick_d  = 1'b0;
        sec_count_d = sec_count_q;
        time_up_d   = 1'b0;
        if (bus.sec_load) begin
            subdiv_d    = '0;
            sec_count_d = bus.sec_value;
        end else begin
            if (bus.run && base_tick_q) begin
                if (subdiv_q == SD_W'(BASE_HZ - 1)) begin
                    subdiv_d   = '0;
                    sec_tick_d = 1'b1;
                end else begin
                    subdiv_d = subdiv_q + SD_W'(1);
                end
            end
            if (sec_tick_q && (sec_count_q != '0)) begin
                sec_count_d = sec_count_q - SEC_W'(1);
                time_up_d   = (sec_count_q == SEC_W'(1));
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            presc_q     <= '0;
            base_tick_q <= 1'b0;
            subdiv_q    <= '0;
            sec_tick_q  <= 1'b0;
            sec_count_q <= '0;
            time_up_q   <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            base_tick_q <= base_tick_d;
            subdiv_q    <= subdiv_d;
            sec_tick_q  <= sec_tick_d;
            sec_count_q <= sec_count_d;
            time_up_q   <= time_up_d;
        end
    end

    assign bus.base_tick = base_tick_q;
    assign bus.ch_tick   = ch_tick;
    assign bus.sec_tick  = sec_tick_q;
    assign bus.sec_count = sec_count_q;
    assign bus.time_up   = time_up_q;

endmodule

// File: doc/game_tick_scheduler.md
Name: game_tick_scheduler

Overview:
Central timing controller for the Frogger game logic. One shared prescaler divides the system clock into a base game tick. Per-lane channels each derive a one-cycle movement strobe at a runtime-programmable rate. A seconds sub-divider drives a loadable level countdown timer. All consumers receive single-cycle enables on Clk; no derived clocks leave this block.

Parameters:
CLK_HZ, 50_000_000, system clock frequency
BASE_HZ, 60, base tick rate; PRESCALE = CLK_HZ/BASE_HZ (integer, >=2)
NUM_CH, 4, number of lane channels
PER_W, 8, channel period register width
SEC_W, 8, countdown timer width

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
run  in  1  global enable; low freezes every counter
cfg_we  in  1  write period for channel cfg_ch
cfg_ch  in  $clog2(NUM_CH)  channel select
cfg_period  in  PER_W  period in base ticks; 0 = channel disabled
sec_load  in  1  load countdown timer
sec_value  in  SEC_W  countdown start value (seconds)
base_tick  out  1  one-cycle strobe at BASE_HZ
ch_tick  out  NUM_CH  one-cycle per-lane strobes
sec_tick  out  1  one-cycle strobe at 1 Hz
sec_count  out  SEC_W  remaining seconds
time_up  out  1  one-cycle pulse when sec_count reaches 0

Behaviour:
- Reset (async, any time): all counters, period registers, sec_count and every output go to 0. Reset mid-operation discards state. Channels are disabled until written.
- Prescaler: counter width $clog2(PRESCALE). Counts 0..PRESCALE-1 while run=1.
  - At PRESCALE-1 it wraps to 0, and base_tick is registered high for the next cycle.
  - First base_tick occurs PRESCALE cycles after Reset falls with run=1.
- run=0: prescaler, channel counters and seconds sub-divider hold. No new strobes are generated. A strobe already registered still completes its single cycle.
- Channel i:
  - Counter increments on base_tick when period_i != 0.
  - When count == period_i-1 and base_tick=1: count wraps to 0, and ch_tick[i] is high the following cycle (1-cycle latency after base_tick).
  - period_i = 1 gives ch_tick[i] one cycle after every base_tick.
- cfg_we: period_i <= cfg_period and count_i <= 0 in the same edge. This takes priority over a coincident base_tick on that channel: no ch_tick is produced from that tick. Other channels are unaffected.
- Seconds sub-divider: counts base_tick events 0..BASE_HZ-1. On the wrap it registers sec_tick high the following cycle.
- Countdown:
  - sec_load: sec_count <= sec_value and the sub-divider is cleared, so the first decrement comes a full second later.
  - On sec_tick with sec_count > 0: decrement. At 0: saturate, no wrap.
  - time_up pulses one cycle, coincident with the cycle sec_count becomes 0, by decrement only.
  - sec_load with sec_value=0 produces no time_up.
- sec_load coincident with sec_tick: load wins, no decrement.
- All outputs are registered. No combinational path from inputs to outputs.

Decomposition:
- Package frogger_tick_pkg:
  - default CLK_HZ/BASE_HZ constants
  - PRESCALE computation function
  - typedefs period_t (PER_W) and sec_t (SEC_W)
- Sub-module tick_channel holds the period register, counter and ch_tick flop.
  - Generated NUM_CH times.
  - Ports: Clk, Reset, run, base_tick, we, period, tick.

Test Plan:
1. CLK_HZ=100, BASE_HZ=10 (PRESCALE=10), run=1 after Reset -> base_tick high exactly on cycles 10, 20, 30 after Reset release; each pulse 1 cycle wide.
2. Write ch0 period=3, ch1 period=0 -> ch_tick[0] one cycle after every 3rd base_tick (cycles 31, 61, ...); ch_tick[1] never asserts.
3. cfg_we to ch0 in the same cycle as its terminal base_tick -> no ch_tick[0]; next ch_tick[0] after 3 further base_ticks.
4. sec_load sec_value=3 -> sec_count 3, 2, 1, 0 at 100-cycle spacing. time_up is a single pulse with the 1->0 transition. sec_count then holds at 0 with no further time_up.
5. Drop run for 25 cycles mid-count -> all strobes shift by exactly 25 cycles and counts are preserved. Assert Reset mid-countdown -> sec_count=0, periods=0, outputs=0 immediately (asynchronous).
6. sec_load coincident with sec_tick, sec_value=5 -> sec_count=5, not 4; next decrement 100 cycles later.
